clint: RTL and testbench

CLINT -- requirements
Module: clint

---
 rtl/clint_if.sv | 27 ++
 rtl/clint.sv | 181 ++++++++++++++++++
 tb/tb_clint.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/clint_if.sv
// Bus interface for the CLINT register block.
//   clint_valid : request strobe, one cycle per request
//   clint_instr : instruction-fetch flag (carried, not used by the CLINT)
//   clint_addr  : byte address
//   clint_wdata : write data
//   clint_wstrb : byte enables, all zero means read
//   clint_rdata : read data, valid while clint_ready is high
//   clint_ready : one-cycle response pulse
interface clint_if;
  logic        clint_valid;
  logic        clint_instr;
  logic [31:0] clint_addr;
  logic [31:0] clint_wdata;
  logic [3:0]  clint_wstrb;
  logic [31:0] clint_rdata;
  logic        clint_ready;

  modport master (
    output clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    input  clint_rdata, clint_ready
  );

  modport slave (
    input  clint_valid, clint_instr, clint_addr, clint_wdata, clint_wstrb,
    output clint_rdata, clint_ready
  );
endinterface

// File: rtl/clint.sv
// Core-local interruptor: 64-bit mtime with prescaler, per-hart mtimecmp and
// msip registers, machine timer / software interrupt outputs.
//   clk        : clock, all state on rising edge
//   rst        : synchronous active-high reset
//   bus        : clint_if slave port (valid/addr/wdata/wstrb in, rdata/ready out)
//   timer_irpt : per-hart machine timer interrupt (registered mtime >= mtimecmp)
//   soft_irpt  : per-hart machine software interrupt (msip register)
// Map: msip[h] 0x0000+4h, mtimecmp[h] 0x4000+8h (lo) / +4 (hi),
//      mtime 0xBFF8 (lo) / 0xBFFC (hi). Only addr[15:0] is decoded.

// Per-hart state: mtimecmp, msip and the registered timer compare.
module clint_hart (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_cmp_lo_i,
  input  logic        we_cmp_hi_i,
  input  logic        we_msip_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wstrb_i,
  input  logic [63:0] mtime_i,
  output logic [63:0] mtimecmp_o,
  output logic        msip_o,
  output logic        timer_o
);
  logic [63:0] cmp_q, cmp_d;
  logic        msip_q, msip_d;
  logic        timer_q;

  always_comb begin
    cmp_d  = cmp_q;
    msip_d = msip_q;
    for (int i = 0; i < 4; i++) begin
      if (we_cmp_lo_i && wstrb_i[i]) cmp_d[8*i +: 8]      = wdata_i[8*i +: 8];
      if (we_cmp_hi_i && wstrb_i[i]) cmp_d[32 + 8*i +: 8] = wdata_i[8*i +: 8];
    end
    // Only the low byte lane carries the msip bit.
    if (we_msip_i && wstrb_i[0]) msip_d = wdata_i[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmp_q   <= '1;
      msip_q  <= 1'b0;
      timer_q <= 1'b0;
    end else begin
      cmp_q   <= cmp_d;
      msip_q  <= msip_d;
      // Compare uses this cycle's mtime/mtimecmp; result appears next cycle.
      timer_q <= (mtime_i >= cmp_q);
    end
  end

  assign mtimecmp_o = cmp_q;
  assign msip_o     = msip_q;
  assign timer_o    = timer_q;
endmodule

module clint #(
  parameter int HARTS    = 2,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  clint_if.slave           bus,
  output logic [HARTS-1:0] timer_irpt,
  output logic [HARTS-1:0] soft_irpt
);
  localparam logic [15:0] PS_LAST = 16'(PRESCALE - 1);

  // ---------------- decode ----------------
  logic [15:0] a;
  logic        wr, rd;
  logic        is_msip, is_cmp, is_mtime;
  logic [11:0] msip_idx;
  logic [10:0] cmp_idx;
  logic        half_hi;

  assign a        = bus.clint_addr[15:0];
  assign wr       = bus.clint_valid && (bus.clint_wstrb != 4'b0000);
  assign rd       = bus.clint_valid && (bus.clint_wstrb == 4'b0000);
  assign is_msip  = (a[15:14] == 2'b00);
  assign is_cmp   = (a[15:14] == 2'b01);
  assign is_mtime = (a[15:3] == 13'h17FF);
  assign msip_idx = a[13:2];
  assign cmp_idx  = a[13:3];
  assign half_hi  = a[2];

  logic unused_bits;
  assign unused_bits = ^{bus.clint_instr, bus.clint_addr[31:16]};

  // ---------------- prescaler / mtime ----------------
  logic [15:0] ps_q, ps_d;
  logic        tick;
  logic [63:0] mtime_q, mtime_d, mtime_base;

  assign tick = (ps_q == PS_LAST);
  assign ps_d = tick ? 16'd0 : ps_q + 16'd1;

  // Bus writes overlay the already-incremented value byte by byte, so a
  // written half never receives a carry and an unwritten half keeps counting.
  always_comb begin
    mtime_base = tick ? mtime_q + 64'd1 : mtime_q;
    mtime_d    = mtime_base;
    if (wr && is_mtime) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.clint_wstrb[i]) begin
          if (half_hi) mtime_d[32 + 8*i +: 8] = bus.clint_wdata[8*i +: 8];
          else         mtime_d[8*i +: 8]      = bus.clint_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= 16'd0;
      mtime_q <= 64'd0;
    end else begin
      ps_q    <= ps_d;
      mtime_q <= mtime_d;
    end
  end

  // ---------------- per-hart registers ----------------
  logic [HARTS-1:0][63:0] cmp_all;
  logic [HARTS-1:0]       msip_all;

  for (genvar h = 0; h < HARTS; h++) begin : g_hart
    logic sel_cmp, sel_msip;
    assign sel_cmp  = wr && is_cmp  && (cmp_idx  == 11'(h));
    assign sel_msip = wr && is_msip && (msip_idx == 12'(h));

    clint_hart u_hart (
      .clk        (clk),
      .rst        (rst),
      .we_cmp_lo_i(sel_cmp && !half_hi),
      .we_cmp_hi_i(sel_cmp &&  half_hi),
      .we_msip_i  (sel_msip),
      .wdata_i    (bus.clint_wdata),
      .wstrb_i    (bus.clint_wstrb),
      .mtime_i    (mtime_q),
      .mtimecmp_o (cmp_all[h]),
      .msip_o     (msip_all[h]),
      .timer_o    (timer_irpt[h])
    );
  end

  assign soft_irpt = msip_all;

  // ---------------- read mux / response ----------------
  // Hart indices at or above HARTS match no loop iteration and read as 0.
  logic [31:0] rd_val;
  always_comb begin
    rd_val = 32'd0;
    if (is_mtime) begin
      rd_val = half_hi ? mtime_q[63:32] : mtime_q[31:0];
    end else begin
      for (int h = 0; h < HARTS; h++) begin
        if (is_msip && msip_idx == 12'(h)) rd_val = {31'd0, msip_all[h]};
        if (is_cmp && cmp_idx == 11'(h))
          rd_val = half_hi ? cmp_all[h][63:32] : cmp_all[h][31:0];
      end
    end
  end

  logic [31:0] rdata_q;
  logic        ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= bus.clint_valid;
      if (rd) rdata_q <= rd_val;
    end
  end

  assign bus.clint_rdata = rdata_q;
  assign bus.clint_ready = ready_q;
endmodule

// File: tb/tb_clint.sv
module tb_clint;
  localparam int HARTS    = 2;
  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  clint_if bus();
  logic [HARTS-1:0] timer_irpt, soft_irpt;

  clint #(.HARTS(HARTS), .PRESCALE(PRESCALE)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .timer_irpt(timer_irpt),
    .soft_irpt (soft_irpt)
  );

  typedef struct {
    logic [31:0] exp;
    int          cyc;
    string       nm;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          cyc    = 0;
  int          t0     = 0;
  logic [31:0] last_rd = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue one request; the expected rdata goes to the scoreboard (a write
  // leaves rdata at the last read value).
  task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] rexp, input string nm);
    exp_t e;
    bus.clint_valid = 1'b1;
    bus.clint_addr  = a;
    bus.clint_wdata = d;
    bus.clint_wstrb = s;
    if (s == 4'b0000) last_rd = rexp;
    e.exp = last_rd;
    e.cyc = cyc;
    e.nm  = nm;
    q.push_back(e);
    step(1);
    bus.clint_valid = 1'b0;
    bus.clint_wstrb = 4'b0000;
  endtask

  // Monitor: every ready pulse must match a queued request, one cycle later.
  always @(negedge clk) begin
    if (bus.clint_ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_ready: got ready=1 expected no response at cycle %0d", cyc);
      end else begin
        mon_e = q.pop_front();
        chk({mon_e.nm, " rdata"}, bus.clint_rdata, mon_e.exp);
        chk({mon_e.nm, " latency"}, 64'(cyc - mon_e.cyc), 64'd1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b, e;
    bus.clint_valid = 1'b0;
    bus.clint_instr = 1'b0;
    bus.clint_addr  = 32'd0;
    bus.clint_wdata = 32'd0;
    bus.clint_wstrb = 4'b0000;
    rst = 1'b1;
    step(3);
    chk("rst ready", {63'd0, bus.clint_ready}, 64'd0);
    chk("rst rdata", {32'd0, bus.clint_rdata}, 64'd0);
    chk("rst timer", {62'd0, timer_irpt}, 64'd0);
    chk("rst soft",  {62'd0, soft_irpt}, 64'd0);
    rst = 1'b0;
    t0  = cyc;

    // mtime after 40 cycles at prescale 4
    step(40);
    req(32'hBFF8, 32'd0, 4'b0000, 32'd10, "mtime_lo_40");
    req(32'hBFFC, 32'd0, 4'b0000, 32'd0,  "mtime_hi_40");

    // byte write into mtimecmp[0], unmapped and out-of-range harts
    req(32'h4000, 32'h00AB_0000, 4'b0100, 32'd0, "cmp0_bytewr");
    req(32'h4000, 32'd0, 4'b0000, 32'hFFAB_FFFF, "cmp0_lo");
    req(32'h4004, 32'd0, 4'b0000, 32'hFFFF_FFFF, "cmp0_hi");
    req(32'h8000, 32'd0, 4'b0000, 32'd0, "unmapped_rd");
    req(32'h8000, 32'h1234_5678, 4'b1111, 32'd0, "unmapped_wr");
    req(32'h0008, 32'hFFFF_FFFF, 4'b1111, 32'd0, "msip2_wr");
    req(32'h0008, 32'd0, 4'b0000, 32'd0, "msip2_rd");
    req(32'h4010, 32'd0, 4'b0000, 32'd0, "cmp2_rd");

    // software interrupt
    req(32'h0004, 32'hFFFF_FFFF, 4'b1111, 32'd0, "msip1_set");
    step(1);
    chk("soft set", {62'd0, soft_irpt}, 64'h2);
    req(32'h0004, 32'd0, 4'b0000, 32'd1, "msip1_rd");
    req(32'h0004, 32'd0, 4'b0010, 32'd0, "msip1_nostrb0");
    req(32'h0004, 32'd0, 4'b0000, 32'd1, "msip1_rd_kept");
    req(32'h0004, 32'd0, 4'b0001, 32'd0, "msip1_clr");
    step(1);
    chk("soft clr", {62'd0, soft_irpt}, 64'h0);
    req(32'h0000, 32'd0, 4'b0000, 32'd0, "msip0_rd");

    // timer interrupt for hart 1 at mtime = 0x20
    req(32'h4008, 32'h0000_0020, 4'b1111, 32'd0, "cmp1_lo_wr");
    req(32'h400C, 32'd0, 4'b1111, 32'd0, "cmp1_hi_wr");
    req(32'h4008, 32'd0, 4'b0000, 32'h20, "cmp1_lo_rd");
    while (cyc < t0 + 128) step(1);
    chk("timer before 0x20", {62'd0, timer_irpt}, 64'h0);
    step(1);
    chk("timer at 0x20", {62'd0, timer_irpt}, 64'h2);
    req(32'hBFF8, 32'd0, 4'b0000, 32'h20, "mtime_lo_20");

    // mtime all-ones then wrap
    req(32'hBFFC, 32'hFFFF_FFFF, 4'b1111, 32'd0, "mtime_hi_wr");
    b = cyc;
    req(32'hBFF8, 32'hFFFF_FFFF, 4'b1111, 32'd0, "mtime_lo_wr");
    e = b + 2;
    while ((e - t0) % PRESCALE != 0) e++;
    while (cyc < e) step(1);
    chk("timer at all-ones", {62'd0, timer_irpt}, 64'h3);
    step(1);
    chk("timer after wrap", {62'd0, timer_irpt}, 64'h0);
    t0 = e;
    step(6);
    req(32'hBFF8, 32'd0, 4'b0000, 32'((cyc - t0) / PRESCALE), "mtime_lo_wrapped");
    req(32'hBFFC, 32'd0, 4'b0000, 32'd0, "mtime_hi_wrapped");

    // reset during a request
    req(32'h0004, 32'd1, 4'b0001, 32'd0, "msip1_set2");
    req(32'h4000, 32'd0, 4'b0000, 32'hFFAB_FFFF, "cmp0_lo_pre_rst");
    step(1);
    chk("soft before rst", {62'd0, soft_irpt}, 64'h2);
    bus.clint_valid = 1'b1;
    bus.clint_addr  = 32'h4008;
    bus.clint_wstrb = 4'b0000;
    rst = 1'b1;
    step(1);
    bus.clint_valid = 1'b0;
    rst = 1'b0;
    t0  = cyc;
    last_rd = 32'd0;
    chk("rst2 ready", {63'd0, bus.clint_ready}, 64'd0);
    chk("rst2 rdata", {32'd0, bus.clint_rdata}, 64'd0);
    chk("rst2 timer", {62'd0, timer_irpt}, 64'd0);
    chk("rst2 soft",  {62'd0, soft_irpt}, 64'd0);
    step(1);
    chk("rst2 no ready", {63'd0, bus.clint_ready}, 64'd0);
    req(32'h4000, 32'd0, 4'b0000, 32'hFFFF_FFFF, "cmp0_lo_post_rst");
    req(32'h400C, 32'd0, 4'b0000, 32'hFFFF_FFFF, "cmp1_hi_post_rst");
    req(32'h0004, 32'd0, 4'b0000, 32'd0, "msip1_post_rst");
    req(32'hBFF8, 32'd0, 4'b0000, 32'((cyc - t0) / PRESCALE), "mtime_post_rst");

    step(3);
    chk("scoreboard drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
